mult_div_unit: RTL and testbench
================================

# mult_div_unit

Sequential signed multiply/divide unit for the multicycle CPU datapath. It receives requests from the control unit over a start/busy/done handshake and takes its operands from the A and B register outputs. It produces the 64-bit product, or the quotient and remainder, on ports that feed the HI and LO registers. The control unit captures the results with HIWrite/LOWrite during the cycle in which `done` is high.

## Interface

Parameters:
- none (datapath width fixed at 32 bits)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  request strobe; sampled only in IDLE or DONE
- op  in  1  operation select: 0 = div, 1 = mult
- a  in  32  operand A (multiplicand / dividend), two's complement
- b  in  32  operand B (multiplier / divisor), two's complement
- busy  out  1  high while a computation is in progress (CALC, FIX)
- done  out  1  high for exactly one cycle when `hi`/`lo` are valid (DONE state)
- hi  out  32  mult: product[63:32]; div: remainder
- lo  out  32  mult: product[31:0]; div: quotient
- div_zero  out  1  last accepted div request had b == 0

## Operation

- States:
  - IDLE: waiting for a request.
  - CALC: 32 iterations, tracked by a 5-bit counter.
  - FIX: sign correction and loading of `hi`/`lo`.
  - DONE: one cycle with `done` high.
- IDLE/DONE + start:
  - Latch `op`, |a|, |b|, sign(a), sign(b).
  - Clear `div_zero`.
  - Counter = 0, next state CALC.
  - Exception: div with b == 0 goes to DONE directly, sets `div_zero`=1, and leaves `hi`/`lo` unchanged.
- IDLE/DONE without start: go to IDLE. DONE always lasts exactly one cycle.
- CALC, mult: unsigned shift-add on the magnitudes, one multiplier bit per cycle, into a 64-bit accumulator.
- CALC, div: unsigned restoring division on the magnitudes, one quotient bit per cycle, with a 33-bit partial remainder.
- CALC → FIX when the counter reaches 31.
- FIX, mult: negate the 64-bit product if sign(a) XOR sign(b), then load `hi`/`lo`.
- FIX, div:
  - Negate the quotient if sign(a) XOR sign(b).
  - Negate the remainder if sign(a) is set.
  - This truncates toward zero; the remainder takes the sign of the dividend (MIPS semantics).
  - Load `hi`/`lo`.
- FIX → DONE.
- Overflow cases wrap modulo 2^32 and raise no flag:
  - |−2^31| is handled as unsigned 0x80000000.
  - 0x80000000 / −1 gives lo = 0x80000000, hi = 0.
- Operands are captured at acceptance. Changes on `a`, `b`, or `op` while busy are ignored.
- `start` in CALC or FIX is ignored and not queued.
- `hi`/`lo` change only in FIX. They hold their value in every other state, including across a div-by-zero.
- `div_zero` holds until the next accepted start or reset.

## Timing

- Reset (reset = 0, asynchronous, takes effect immediately):
  - state = IDLE, counter = 0.
  - `busy` = `done` = `div_zero` = 0.
  - `hi` = `lo` = 0x00000000.
- Reset mid-operation aborts the operation. Computation resumes only on a new start after reset is released.
- Start sampled at edge E0:
  - `busy` goes high after E0.
  - CALC occupies edges E1..E32.
  - FIX is entered after E32; `hi`/`lo` are written at E33.
  - `done` is high between E33 and E34, with `busy` = 0.
- Latency is 33 cycles from the accepting edge to `done`, and it is identical for mult and div.
- Divide by zero: start at E0 → `done` = 1 and `div_zero` = 1 between E0 and E1; `busy` never rises.
- Back-to-back: a start seen in DONE at E34 is accepted. Throughput is one operation per 34 cycles.
- `busy` and `done` are never high in the same cycle.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan

- Signed mult: op=1, a=7, b=0xFFFFFFFD (−3), start 1 cycle → `busy` for 33 cycles, then `done` for 1 cycle with hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- Extreme mult: a=b=0x80000000 → hi=0x40000000, lo=0x00000000. Then a=0xFFFFFFFF, b=0xFFFFFFFF → hi=0, lo=1.
- Signed div: op=0, a=0xFFFFFFF9 (−7), b=2 → lo=0xFFFFFFFD (−3), hi=0xFFFFFFFF (−1). Then a=7, b=0xFFFFFFFE → lo=0xFFFFFFFD, hi=1.
- Divide by zero: preload hi/lo via 100/7 (lo=14, hi=2). Then div a=5, b=0 → `done` on the very next cycle, `div_zero`=1, hi=2, lo=14 unchanged. Next accepted mult clears `div_zero`.
- Overflow div: a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0, `div_zero`=0.
- Robustness:
  - Change a/b and pulse start during CALC → result reflects the original operands and there is no second `done`.
  - Assert reset at cycle 10 of a mult → `busy`/`done`/`hi`/`lo` all 0 immediately, and no `done` follows after release.

Source files
------------

// File: rtl/mult_div_unit.sv
// mult_div_unit
// Sequential signed 32x32 multiply / 32/32 divide unit for the multicycle
// CPU datapath. A request is accepted on `start` in IDLE or DONE. The unit
// spends 32 cycles iterating on operand magnitudes and one cycle applying
// sign correction. It then presents the result for one cycle with `done`.
//
// Ports:
//   clk       rising-edge clock
//   reset     asynchronous, active-low reset
//   start     request strobe (ignored while busy)
//   op        0 = signed divide, 1 = signed multiply
//   a, b      operands (multiplicand/dividend, multiplier/divisor)
//   busy      computation in progress (CALC or FIX)
//   done      one-cycle result-valid strobe
//   hi, lo    mult: product[63:32] / product[31:0]; div: remainder / quotient
//   div_zero  last accepted divide had a zero divisor
module mult_div_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        div_zero
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        isMult_q, isMult_d;
  logic        signA_q, signA_d;
  logic        signB_q, signB_d;
  // mult: upper product half / div: partial remainder
  logic [31:0] accHi_q, accHi_d;
  // mult: multiplier shifting out, product low half shifting in
  // div:  dividend shifting out, quotient bits shifting in
  logic [31:0] accLo_q, accLo_d;
  // mult: multiplicand magnitude / div: divisor magnitude
  logic [31:0] operand_q, operand_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        divZero_q, divZero_d;

  logic [31:0] magA, magB;
  logic [32:0] multSum;
  logic [32:0] divShift;
  logic        divGe;
  logic [31:0] divDiff;
  logic [63:0] product, productFix;
  logic [31:0] quoFix, remFix;

  // |-2^31| wraps to 0x80000000, which is the correct unsigned magnitude.
  assign magA = a[31] ? (~a + 32'd1) : a;
  assign magB = b[31] ? (~b + 32'd1) : b;

  // Shift-add step: add the multiplicand when the current multiplier bit is
  // set, then shift the 64-bit {accHi, accLo} right by one.
  assign multSum = {1'b0, accHi_q} + (accLo_q[0] ? {1'b0, operand_q} : 33'd0);

  // Restoring-division step. The shifted partial remainder needs 33 bits.
  // When it is >= divisor, the difference always fits in 32 bits, so a
  // 32-bit subtraction is exact.
  assign divShift = {accHi_q, accLo_q[31]};
  assign divGe    = (divShift >= {1'b0, operand_q});
  assign divDiff  = divShift[31:0] - operand_q;

  assign product    = {accHi_q, accLo_q};
  assign productFix = (signA_q ^ signB_q) ? (~product + 64'd1) : product;
  assign quoFix     = (signA_q ^ signB_q) ? (~accLo_q + 32'd1) : accLo_q;
  assign remFix     = signA_q ? (~accHi_q + 32'd1) : accHi_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    isMult_d  = isMult_q;
    signA_d   = signA_q;
    signB_d   = signB_q;
    accHi_d   = accHi_q;
    accLo_d   = accLo_q;
    operand_d = operand_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    divZero_d = divZero_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          if (!op && (b == 32'd0)) begin
            // Divide by zero finishes at once and leaves hi/lo untouched.
            state_d   = DONE;
            divZero_d = 1'b1;
          end else begin
            state_d   = CALC;
            divZero_d = 1'b0;
            cnt_d     = 5'd0;
            isMult_d  = op;
            signA_d   = a[31];
            signB_d   = b[31];
            accHi_d   = 32'd0;
            accLo_d   = op ? magB : magA;
            operand_d = op ? magA : magB;
          end
        end else begin
          state_d = IDLE;
        end
      end

      CALC: begin
        if (isMult_q) begin
          accHi_d = multSum[32:1];
          accLo_d = {multSum[0], accLo_q[31:1]};
        end else begin
          accHi_d = divGe ? divDiff : divShift[31:0];
          accLo_d = {accLo_q[30:0], divGe};
        end
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d = FIX;
        end
      end

      FIX: begin
        if (isMult_q) begin
          hi_d = productFix[63:32];
          lo_d = productFix[31:0];
        end else begin
          hi_d = remFix;
          lo_d = quoFix;
        end
        state_d = DONE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= 5'd0;
      isMult_q  <= 1'b0;
      signA_q   <= 1'b0;
      signB_q   <= 1'b0;
      accHi_q   <= 32'd0;
      accLo_q   <= 32'd0;
      operand_q <= 32'd0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      divZero_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      isMult_q  <= isMult_d;
      signA_q   <= signA_d;
      signB_q   <= signB_d;
      accHi_q   <= accHi_d;
      accLo_q   <= accLo_d;
      operand_q <= operand_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      divZero_q <= divZero_d;
    end
  end

  // Status flags decode directly from the state register.
  assign busy     = (state_q == CALC) || (state_q == FIX);
  assign done     = (state_q == DONE);
  assign hi       = hi_q;
  assign lo       = lo_q;
  assign div_zero = divZero_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit
// Directed testbench for mult_div_unit. A cycle-level reference model
// derives the expected outputs from plain signed arithmetic and a
// cycles-remaining timer. Each cycle, the DUT outputs are compared against
// this model. Hand-computed literals pin the results of each directed case.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        div_zero;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mult_div_unit dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .hi       (hi),
    .lo       (lo),
    .div_zero (div_zero)
  );

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference result: {hi, lo} from signed 64-bit arithmetic. Division
  // truncates toward zero, and the remainder follows the dividend's sign.
  function automatic logic [63:0] refResult(input logic o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, p, q, r;
    sx = $signed(x);
    sy = $signed(y);
    if (o) begin
      p = sx * sy;
      return p;
    end
    q = sx / sy;
    r = sx % sy;
    return {r[31:0], q[31:0]};
  endfunction

  // Cycle-level model: an accepted request yields done 33 edges later.
  int          remaining = 0;
  logic        expBusy = 1'b0;
  logic        expDone = 1'b0;
  logic        expDz = 1'b0;
  logic [31:0] expHi = 32'd0;
  logic [31:0] expLo = 32'd0;
  logic [31:0] pendHi = 32'd0;
  logic [31:0] pendLo = 32'd0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      remaining = 0;
      expBusy = 1'b0;
      expDone = 1'b0;
      expDz = 1'b0;
      expHi = 32'd0;
      expLo = 32'd0;
    end else if (remaining > 0) begin
      remaining--;
      if (remaining == 0) begin
        expBusy = 1'b0;
        expDone = 1'b1;
        expHi = pendHi;
        expLo = pendLo;
      end
    end else begin
      expDone = 1'b0;
      if (start) begin
        if (!op && b == 32'd0) begin
          expDone = 1'b1;
          expDz = 1'b1;
        end else begin
          {pendHi, pendLo} = refResult(op, a, b);
          expDz = 1'b0;
          expBusy = 1'b1;
          remaining = 33;
        end
      end
    end
  end

  // Compare every output against the model on each falling edge.
  always @(negedge clk) begin
    checkOutput("cyc_busy", {31'd0, busy}, {31'd0, expBusy});
    checkOutput("cyc_done", {31'd0, done}, {31'd0, expDone});
    checkOutput("cyc_divzero", {31'd0, div_zero}, {31'd0, expDz});
    checkOutput("cyc_hi", hi, expHi);
    checkOutput("cyc_lo", lo, expLo);
  end

  // Wait for done; start is dropped after the accepting edge.
  task automatic waitDone(output int busyCycles, output bit gotDone);
    busyCycles = 0;
    gotDone = 1'b0;
    for (int i = 0; i < 40 && !gotDone; i++) begin
      @(posedge clk);
      #1;
      if (i == 0) start = 1'b0;
      if (busy) busyCycles++;
      if (done) gotDone = 1'b1;
    end
  endtask

  task automatic applyStimulus(input string name, input bit backToBack, input logic o,
                               input logic [31:0] x, input logic [31:0] y,
                               input logic [31:0] wantHi, input logic [31:0] wantLo,
                               input int wantBusy, input logic wantDz);
    int bc;
    bit gd;
    if (backToBack) #1;
    else begin
      @(posedge clk);
      #2;
    end
    op = o;
    a = x;
    b = y;
    start = 1'b1;
    waitDone(bc, gd);
    checkOutput({name, "_done_seen"}, {31'd0, gd}, 32'd1);
    checkOutput({name, "_hi"}, hi, wantHi);
    checkOutput({name, "_lo"}, lo, wantLo);
    checkOutput({name, "_busy_cycles"}, bc, wantBusy);
    checkOutput({name, "_divzero"}, {31'd0, div_zero}, {31'd0, wantDz});
  endtask

  task automatic countDones(input string name, input int cycles);
    int n;
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      if (done) n++;
    end
    checkOutput(name, n, 0);
  endtask

  initial begin
    int bc;
    bit gd;
    reset = 1'b0;
    start = 1'b0;
    op = 1'b0;
    a = 32'd0;
    b = 32'd0;
    repeat (3) @(posedge clk);
    #2;
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    checkOutput("reset_done", {31'd0, done}, 32'd0);
    checkOutput("reset_divzero", {31'd0, div_zero}, 32'd0);
    checkOutput("reset_hi", hi, 32'd0);
    checkOutput("reset_lo", lo, 32'd0);
    reset = 1'b1;

    applyStimulus("mul_7_m3", 0, 1'b1, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 33, 1'b0);
    applyStimulus("mul_min_min", 0, 1'b1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 33, 1'b0);
    applyStimulus("mul_m1_m1", 0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd1, 33, 1'b0);
    applyStimulus("div_m7_2", 0, 1'b0, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 33, 1'b0);
    applyStimulus("div_7_m2", 0, 1'b0, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, 33, 1'b0);
    applyStimulus("div_100_7", 0, 1'b0, 32'd100, 32'd7, 32'd2, 32'd14, 33, 1'b0);
    applyStimulus("div_by_zero", 0, 1'b0, 32'd5, 32'd0, 32'd2, 32'd14, 0, 1'b1);
    applyStimulus("mul_clears_dz", 0, 1'b1, 32'd3, 32'd5, 32'd0, 32'd15, 33, 1'b0);
    applyStimulus("div_overflow", 0, 1'b0, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 33, 1'b0);
    applyStimulus("back_to_back", 1, 1'b1, 32'd2, 32'd3, 32'd0, 32'd6, 33, 1'b0);

    // Operand changes and a start pulse during CALC must not disturb the result.
    @(posedge clk);
    #2;
    op = 1'b1;
    a = 32'd1000;
    b = 32'hFFFFF830;
    start = 1'b1;
    @(posedge clk);
    #2;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    op = 1'b0;
    a = 32'd5;
    b = 32'd6;
    start = 1'b1;
    @(posedge clk);
    #2;
    start = 1'b0;
    waitDone(bc, gd);
    checkOutput("robust_done_seen", {31'd0, gd}, 32'd1);
    checkOutput("robust_hi", hi, 32'hFFFFFFFF);
    checkOutput("robust_lo", lo, 32'hFFE17B80);
    countDones("robust_no_second_done", 40);

    // Reset in the middle of a multiply aborts it at once.
    @(posedge clk);
    #2;
    op = 1'b1;
    a = 32'd7;
    b = 32'hFFFFFFFD;
    start = 1'b1;
    @(posedge clk);
    #2;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("midreset_busy", {31'd0, busy}, 32'd0);
    checkOutput("midreset_done", {31'd0, done}, 32'd0);
    checkOutput("midreset_hi", hi, 32'd0);
    checkOutput("midreset_lo", lo, 32'd0);
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b1;
    countDones("midreset_no_done", 40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
